dmem_ctl: RTL and testbench
===========================

Name: dmem_ctl

Overview:
- Parametrised data-memory controller; successor to the fixed 8-bit, 256-entry byte store.
- Byte-addressed array of 2**AW bytes, accessed by byte or half-word (2 bytes, little-endian).
- Effective address is rd1+disp; loads are sign- or zero-extended, returned registered with a valid pulse.
- Sits in the mem_IO stage (kind=4'b0011). Post-reset hardware clear sweep zeroes the array.

Parameters:
- DW, 8, byte lane width in bits; data ports are 2*DW.
- AW, 8, address width; depth = 2**AW bytes.
- CLR_EN, 1, 1 = zero-fill sweep after reset; 0 = no sweep.

Ports:
- ck  in  1  clock; all state changes on posedge.
- res  in  1  synchronous active-low reset.
- ck2  in  1  phase enable; registers advance only on edges where ck2==0, else hold.
- req  in  1  access request.
- kind  in  4  instruction class; only 4'b0011 is accepted.
- fn2  in  2  2'b00 load, 2'b01 store; 2'b10/2'b11 = no-op.
- size  in  1  0 byte, 1 half-word.
- sext  in  1  byte loads only: 1 sign-extend, 0 zero-extend.
- rd1  in  AW  base address.
- disp  in  AW  displacement.
- store_d  in  2*DW  store data; byte store uses [DW-1:0].
- load_d  out  2*DW  registered load data.
- load_vld  out  1  load_d valid, one enabled cycle.
- busy  out  1  controller cannot accept a request.
- clr_done  out  1  clear sweep finished; stays 1 until next reset.

Behaviour:
- Reset: at posedge ck with res==0, regardless of ck2:
  - load_d=0, load_vld=0, clr_done=0, pointer=0, busy=CLR_EN.
  - State = CLEAR (CLR_EN=1) or INIT (CLR_EN=0).
  - Array contents untouched by reset itself.
- Enabled edge = posedge ck with res==1 and ck2==0. Non-enabled edges hold every register, including load_vld.
- EA = (rd1+disp) mod 2**AW. EA1 = (EA+1) mod 2**AW (wraps 2**AW-1 -> 0). No alignment requirement.
- CLEAR: each enabled edge writes 0 to byte[ptr], ptr++.
  - Write of ptr=2**AW-1 -> IDLE, clr_done=1, busy=0 on the same edge.
  - Takes 2**AW enabled cycles; requests ignored.
- INIT (CLR_EN=0): one enabled edge -> IDLE, clr_done=1, busy=0.
- IDLE: accept when req==1 and kind==4'b0011 and fn2 is 00 or 01. Otherwise nothing changes, except load_vld is cleared.
  - Byte load: load_d = ext(byte[EA]), load_vld=1 on the accepting edge. Latency 1; stay IDLE.
  - Byte store: byte[EA] = store_d[DW-1:0] on the accepting edge; no load_vld.
  - Half load: capture byte[EA] into load_d[DW-1:0], -> HALF2, busy=1.
  - Half store: write byte[EA] = store_d[DW-1:0], -> HALF2, busy=1.
  - EA1, op, and store_d[2*DW-1:DW] are latched at acceptance; later input changes have no effect.
- HALF2, next enabled edge:
  - Load: load_d[2*DW-1:DW] = byte[EA1], load_vld=1.
  - Store: byte[EA1] = latched high byte.
  - Then -> IDLE, busy=0. Half load has latency 2; sext is ignored.
- load_vld is high exactly one enabled cycle and clears on the next enabled edge. load_d holds its last value until the next load.
- Back-to-back: a request may be accepted on the same edge that HALF2 returns to IDLE? No. busy is 1 throughout HALF2, so the next request is accepted on the following enabled edge.
- Reset mid-operation:
  - Aborts HALF2; the second byte of a half store is not written.
  - Aborts CLEAR and restarts the sweep from 0.
- Byte load of an address stored on the previous enabled edge returns the new value.

Test Plan:
1. AW=8, CLR_EN=1: release res, hold ck2=0 -> busy=1 for 256 cycles, then clr_done=1, busy=0. Byte load of 8'hA7 returns 16'h0000.
2. Byte store 8'h85 at rd1=8'hF0, disp=8'h05; then byte load EA 8'hF5 with sext=1 -> load_d=16'hFF85, load_vld 1 cycle after acceptance. With sext=0 -> 16'h0085.
3. Half store 16'hBEEF at rd1=8'hFF, disp=8'h00 -> byte[FF]=EF, byte[00]=BE (wrap), busy high 1 cycle. Half load at same EA -> 16'hBEEF, load_vld 2 cycles after acceptance.
4. Toggle ck2=1 for 3 cycles mid-HALF2 and while load_vld=1 -> state, busy, load_vld, load_d all frozen; completion resumes on the next ck2=0 edge.
5. req=1 with kind=4'b0010, or fn2=2'b10 -> no write, load_vld stays 0. req during CLEAR -> ignored, array stays 0.
6. Assert res during HALF2 of a half store of 16'h1234 at EA 8'h10 -> byte[10]=34, byte[11] unchanged. Sweep restarts at 0, clr_done=0 until the sweep completes.

Source files
------------

// File: rtl/dmem_ctl.sv
// dmem_ctl: byte-addressed data memory for the mem_IO stage.
// Supports byte and little-endian half-word loads and stores at address rd1+disp.
// Loads are returned registered, with a one-cycle valid pulse.
// After reset, an optional sweep writes zero to every byte of the array.
module dmem_ctl #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter bit CLR_EN = 1'b1
) (
    input  logic            ck,
    input  logic            res,
    input  logic            ck2,
    input  logic            req,
    input  logic [3:0]      kind,
    input  logic [1:0]      fn2,
    input  logic            size,
    input  logic            sext,
    input  logic [AW-1:0]   rd1,
    input  logic [AW-1:0]   disp,
    input  logic [2*DW-1:0] store_d,
    output logic [2*DW-1:0] load_d,
    output logic            load_vld,
    output logic            busy,
    output logic            clr_done
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_INIT,
        S_IDLE,
        S_HALF2
    } state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [DW-1:0]   mem [DEPTH];

    logic            en;
    logic            accept;
    logic            is_store;
    logic [AW-1:0]   ea;

    logic [AW-1:0]   ea1_p0;
    logic [DW-1:0]   hi_p0;
    logic            store_p0;

    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;

    // Widen one byte to the data-port width, with optional sign extension.
    function automatic logic [2*DW-1:0] ext_byte(input logic [DW-1:0] b, input logic sx);
        logic signed [DW-1:0]   sb;
        logic signed [2*DW-1:0] sw;
        sb = signed'(b);
        sw = (2*DW)'(sb);
        return sx ? $unsigned(sw) : {{DW{1'b0}}, b};
    endfunction

    // Registers only move on edges where ck2 is low; reset overrides this gating.
    assign en       = res && !ck2;
    assign ea       = rd1 + disp;
    assign accept   = (state == S_IDLE) && req && (kind == 4'b0011) && !fn2[1];
    assign is_store = fn2[0];

    // Select the single write port source: the clear sweep, a store's first byte, or a half store's high byte.
    always_comb begin
        we    = 1'b0;
        waddr = ptr;
        wdata = '0;
        case (state)
            S_CLEAR: begin
                we    = 1'b1;
                waddr = ptr;
                wdata = '0;
            end
            S_IDLE: begin
                if (accept && is_store) begin
                    we    = 1'b1;
                    waddr = ea;
                    wdata = store_d[DW-1:0];
                end
            end
            S_HALF2: begin
                if (store_p0) begin
                    we    = 1'b1;
                    waddr = ea1_p0;
                    wdata = hi_p0;
                end
            end
            default: ;
        endcase
    end

    // Byte array write; reset leaves the contents untouched.
    always_ff @(posedge ck) begin
        if (we && en) begin
            mem[waddr] <= wdata;
        end
    end

    // Controller FSM with registered outputs: clear sweep, idle accept, and the second half-word byte.
    always_ff @(posedge ck) begin
        if (!res) begin
            state    <= CLR_EN ? S_CLEAR : S_INIT;
            ptr      <= '0;
            load_d   <= '0;
            load_vld <= 1'b0;
            busy     <= CLR_EN;
            clr_done <= 1'b0;
        end else if (!ck2) begin
            load_vld <= 1'b0;
            case (state)
                S_CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == {AW{1'b1}}) begin
                        state    <= S_IDLE;
                        clr_done <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                S_INIT: begin
                    state    <= S_IDLE;
                    clr_done <= 1'b1;
                    busy     <= 1'b0;
                end
                S_IDLE: begin
                    if (accept) begin
                        if (!size) begin
                            if (!is_store) begin
                                load_d   <= ext_byte(mem[ea], sext);
                                load_vld <= 1'b1;
                            end
                        end else begin
                            // Stage p0: latch the second-byte address, operation and high data at acceptance
                            ea1_p0   <= ea + AW'(1);
                            hi_p0    <= store_d[2*DW-1:DW];
                            store_p0 <= is_store;
                            busy     <= 1'b1;
                            state    <= S_HALF2;
                            if (!is_store) begin
                                load_d[DW-1:0] <= mem[ea];
                            end
                        end
                    end
                end
                S_HALF2: begin
                    if (!store_p0) begin
                        load_d[2*DW-1:DW] <= mem[ea1_p0];
                        load_vld          <= 1'b1;
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctl.sv
// Testbench for dmem_ctl: directed vectors with hand-computed expectations.
// Expected load results go into a queue; a monitor compares them on each valid pulse.
// A second instance with CLR_EN=0 checks array contents across a mid-operation reset.
module tb_dmem_ctl;

    logic        ck = 1'b0;
    logic        res = 1'b0;
    logic        res2 = 1'b0;
    logic        ck2 = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  kind = 4'b0000;
    logic [1:0]  fn2 = 2'b00;
    logic        size = 1'b0;
    logic        sext = 1'b0;
    logic [7:0]  rd1 = 8'h00;
    logic [7:0]  disp = 8'h00;
    logic [15:0] store_d = 16'h0000;

    logic [15:0] load_d, load_d2;
    logic        load_vld, load_vld2;
    logic        busy, busy2;
    logic        clr_done, clr_done2;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] exp_q[$];
    logic [15:0] sb_e;
    logic        en_edge = 1'b0;
    int          sw;

    dmem_ctl #(.DW(8), .AW(8), .CLR_EN(1'b1)) dut (
        .ck(ck), .res(res), .ck2(ck2), .req(req), .kind(kind), .fn2(fn2),
        .size(size), .sext(sext), .rd1(rd1), .disp(disp), .store_d(store_d),
        .load_d(load_d), .load_vld(load_vld), .busy(busy), .clr_done(clr_done)
    );

    dmem_ctl #(.DW(8), .AW(8), .CLR_EN(1'b0)) dut2 (
        .ck(ck), .res(res2), .ck2(ck2), .req(req), .kind(kind), .fn2(fn2),
        .size(size), .sext(sext), .rd1(rd1), .disp(disp), .store_d(store_d),
        .load_d(load_d2), .load_vld(load_vld2), .busy(busy2), .clr_done(clr_done2)
    );

    always #5 ck = ~ck;

    // Record whether the edge just taken was an enabled edge.
    always @(posedge ck) en_edge <= res && !ck2;

    // Scoreboard monitor: each fresh valid pulse from the main instance consumes one expectation.
    always @(negedge ck) begin
        if (en_edge && load_vld === 1'b1) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL sb_unexpected: load_d=%h with no load expected", load_d);
            end else begin
                sb_e = exp_q.pop_front();
                if (load_d !== sb_e) begin
                    nerr++;
                    $display("FAIL sb_load_d: got %h expected %h", load_d, sb_e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic acc(input logic [3:0] k, input logic [1:0] f, input logic sz, input logic sx,
                       input logic [7:0] a, input logic [7:0] d, input logic [15:0] sd);
        req = 1'b1; kind = k; fn2 = f; size = sz; sext = sx; rd1 = a; disp = d; store_d = sd;
        step();
        req = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_load_vld", 32'(load_vld), 32'd0);
        chk("rst_load_d", 32'(load_d), 32'h0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_clr_done", 32'(clr_done), 32'd0);

        // Clear sweep of 256 enabled edges; a store issued mid-sweep must be ignored
        res = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            if (i == 101) begin
                req = 1'b1; kind = 4'b0011; fn2 = 2'b01; size = 1'b0;
                rd1 = 8'h10; disp = 8'h00; store_d = 16'h005A;
            end
            if (i == 102) req = 1'b0;
            step();
            if (i == 255) begin
                chk("sweep_busy_255", 32'(busy), 32'd1);
                chk("sweep_done_255", 32'(clr_done), 32'd0);
            end
        end
        chk("sweep_busy_256", 32'(busy), 32'd0);
        chk("sweep_done_256", 32'(clr_done), 32'd1);

        // Byte load of a cleared location, latency 1
        exp_q.push_back(16'h0000);
        acc(4'b0011, 2'b00, 1'b0, 1'b1, 8'hA7, 8'h00, 16'h0);
        chk("bload_vld_lat1", 32'(load_vld), 32'd1);
        step();
        chk("bload_vld_clear", 32'(load_vld), 32'd0);

        // Byte store then sign- and zero-extended loads at EA F0+05
        acc(4'b0011, 2'b01, 1'b0, 1'b0, 8'hF0, 8'h05, 16'hCC85);
        exp_q.push_back(16'hFF85);
        acc(4'b0011, 2'b00, 1'b0, 1'b1, 8'hF5, 8'h00, 16'h0);
        exp_q.push_back(16'h0085);
        acc(4'b0011, 2'b00, 1'b0, 1'b0, 8'hF0, 8'h05, 16'h0);

        // Half store across the address wrap, then half load back
        acc(4'b0011, 2'b01, 1'b1, 1'b0, 8'hFF, 8'h00, 16'hBEEF);
        chk("hstore_busy", 32'(busy), 32'd1);
        step();
        chk("hstore_busy_done", 32'(busy), 32'd0);
        exp_q.push_back(16'hBEEF);
        acc(4'b0011, 2'b00, 1'b1, 1'b1, 8'hFF, 8'h00, 16'h0);
        chk("hload_vld_lat1", 32'(load_vld), 32'd0);
        chk("hload_busy", 32'(busy), 32'd1);
        step();
        chk("hload_vld_lat2", 32'(load_vld), 32'd1);
        chk("hload_busy_done", 32'(busy), 32'd0);
        exp_q.push_back(16'h00EF);
        acc(4'b0011, 2'b00, 1'b0, 1'b0, 8'hFF, 8'h00, 16'h0);
        exp_q.push_back(16'hFFBE);
        acc(4'b0011, 2'b00, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0);

        // Phase-enable freeze during HALF2 and while load_vld is high
        acc(4'b0011, 2'b01, 1'b1, 1'b0, 8'h20, 8'h00, 16'h2211);
        step();
        exp_q.push_back(16'h2211);
        acc(4'b0011, 2'b00, 1'b1, 1'b0, 8'h18, 8'h08, 16'h0);
        ck2 = 1'b1;
        repeat (3) step();
        chk("frz_busy", 32'(busy), 32'd1);
        chk("frz_vld", 32'(load_vld), 32'd0);
        ck2 = 1'b0;
        step();
        chk("frz_resume_vld", 32'(load_vld), 32'd1);
        chk("frz_resume_busy", 32'(busy), 32'd0);
        ck2 = 1'b1;
        repeat (3) step();
        chk("frz_hold_vld", 32'(load_vld), 32'd1);
        chk("frz_hold_d", 32'(load_d), 32'h2211);
        ck2 = 1'b0;
        step();
        chk("frz_vld_clear", 32'(load_vld), 32'd0);

        // Rejected requests: wrong kind and no-op fn2
        acc(4'b0010, 2'b00, 1'b0, 1'b0, 8'h30, 8'h00, 16'h0);
        chk("rej_kind_vld", 32'(load_vld), 32'd0);
        acc(4'b0010, 2'b01, 1'b0, 1'b0, 8'h30, 8'h00, 16'h0077);
        acc(4'b0011, 2'b10, 1'b0, 1'b0, 8'h30, 8'h00, 16'h0077);
        acc(4'b0011, 2'b11, 1'b1, 1'b0, 8'h30, 8'h00, 16'h7777);
        chk("rej_fn2_busy", 32'(busy), 32'd0);
        exp_q.push_back(16'h0000);
        acc(4'b0011, 2'b00, 1'b1, 1'b0, 8'h30, 8'h00, 16'h0);
        step();
        exp_q.push_back(16'h0000);
        acc(4'b0011, 2'b00, 1'b0, 1'b0, 8'h10, 8'h00, 16'h0);

        // Reset during HALF2 of a half store; second instance keeps its array
        res2 = 1'b1;
        chk("i2_done_pre", 32'(clr_done2), 32'd0);
        step();
        chk("i2_done", 32'(clr_done2), 32'd1);
        chk("i2_busy", 32'(busy2), 32'd0);
        acc(4'b0011, 2'b01, 1'b0, 1'b0, 8'h11, 8'h00, 16'h0099);
        acc(4'b0011, 2'b01, 1'b1, 1'b0, 8'h08, 8'h08, 16'h1234);
        res = 1'b0;
        res2 = 1'b0;
        step();
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_done", 32'(clr_done), 32'd0);
        chk("midrst_vld", 32'(load_vld), 32'd0);
        chk("midrst_load_d", 32'(load_d), 32'h0);
        chk("midrst_i2_done", 32'(clr_done2), 32'd0);
        res = 1'b1;
        res2 = 1'b1;
        sw = 0;
        step(); sw++;
        acc(4'b0011, 2'b00, 1'b0, 1'b0, 8'h10, 8'h00, 16'h0); sw++;
        chk("i2_b10", 32'(load_d2), 32'h0034);
        chk("i2_b10_vld", 32'(load_vld2), 32'd1);
        acc(4'b0011, 2'b00, 1'b0, 1'b0, 8'h11, 8'h00, 16'h0); sw++;
        chk("i2_b11", 32'(load_d2), 32'h0099);
        acc(4'b0011, 2'b00, 1'b1, 1'b0, 8'h10, 8'h00, 16'h0); sw++;
        step(); sw++;
        chk("i2_h10", 32'(load_d2), 32'h9934);
        chk("resweep_done_early", 32'(clr_done), 32'd0);
        while (clr_done !== 1'b1 && sw < 300) begin
            step();
            sw++;
        end
        chk("resweep_len", 32'(sw), 32'd256);
        exp_q.push_back(16'h0000);
        acc(4'b0011, 2'b00, 1'b0, 1'b0, 8'h10, 8'h00, 16'h0);
        exp_q.push_back(16'h0000);
        acc(4'b0011, 2'b00, 1'b0, 1'b1, 8'h11, 8'h00, 16'h0);
        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
